ftdi_tx: RTL and testbench
==========================

FTDI_TX -- requirements
Module: ftdi_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, byte FIFO depth; power of two, at least 4.
REQ-002 Parameter MAX_BURST, default 8, maximum bytes per bus ownership; range 1..255.
REQ-003 clk_60  input  1  60MHz FTDI clock; all logic is in this domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 push  input  1  write strobe; din is enqueued on a rising edge where push=1 and full=0.
REQ-006 din  input  8  byte to enqueue.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-009 overflow  output  1  sticky; set by a push while full.
REQ-010 txe_n  input  1  FTDI transmit-FIFO-full flag, active low = space available.
REQ-011 rx_busy  input  1  receive side currently owns the shared bus.
REQ-012 wr_n  output  1  FTDI write strobe, registered, active low.
REQ-013 data_oe  output  1  drive enable for the bidirectional data bus, registered.
REQ-014 data_out  output  8  byte driven onto the bus.
REQ-015 tx_busy  output  1  transmit side owns the bus; high in every state except IDLE.
REQ-016 sent_count  output  16  bytes accepted by the FTDI, wraps at 2^16.

Function
REQ-017 Handshake: a byte is accepted on a rising edge where wr_n=0 and txe_n=0, both sampled at that edge; only this event pops the FIFO and increments sent_count.
REQ-018 The FIFO shall be show-ahead: data_out equals the FIFO head in TURN and SEND; after a pop the next head is presented by the following edge.
REQ-019 States: IDLE, TURN, SEND, RELEASE.
REQ-020 IDLE: wr_n=1, data_oe=0; go to TURN when level>0, rx_busy=0 and txe_n=0.
REQ-021 TURN (1 cycle): data_oe=1, wr_n=1, burst counter cleared; go to SEND.
REQ-022 SEND: data_oe=1, wr_n=0 for every cycle in the state.
REQ-023 SEND exits to RELEASE on the first edge where any of these hold: a byte is accepted and the burst count reaches MAX_BURST; a byte is accepted and the FIFO becomes empty (after any same-cycle push); or txe_n=1.
REQ-024 When SEND exits with txe_n=1, no pop occurs; the unaccepted byte stays at the head.
REQ-025 RELEASE (1 cycle): wr_n=1, data_oe=0; go to IDLE. A new burst needs at least one IDLE cycle.
REQ-026 rx_busy is examined only in IDLE; once TURN is entered, the burst completes under REQ-023.
REQ-027 Simultaneous push and pop with the FIFO not full: both take effect; level is unchanged.
REQ-028 Push while full: the byte is dropped and overflow is set, even if a pop occurs in the same cycle.
REQ-029 level counts bytes exactly, from 0 to FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 On an edge with rst=1, regardless of state: state=IDLE, wr_n=1, data_oe=0, tx_busy=0, FIFO emptied (level=0, full=0), overflow=0, sent_count=0, data_out=0x00.
REQ-031 A burst interrupted by reset is abandoned; bytes not yet accepted are discarded.

Verification
REQ-032 Push 0x11,0x22,0x33 with txe_n=0 and rx_busy=0 -> IDLE, TURN, 3 SEND cycles with data_out 11,22,33, then RELEASE, IDLE; sent_count=3.
REQ-033 MAX_BURST=8, push 12 bytes -> 8 bytes sent, RELEASE, IDLE, TURN, remaining 4 bytes sent; wr_n high for at least 3 cycles between bursts.
REQ-034 txe_n=1 during the 2nd SEND cycle -> RELEASE with byte 2 still at the head; after txe_n=0, the next burst resends byte 2 first; no byte is lost or duplicated.
REQ-035 rx_busy=1 with level>0 -> remains in IDLE with wr_n=1 and data_oe=0; starts TURN the cycle after rx_busy falls.
REQ-036 Fill to 16, then push 0xAA -> full=1, overflow=1, level stays 16, 0xAA is never transmitted.
REQ-037 Assert rst in the middle of SEND -> next edge wr_n=1, data_oe=0, level=0, sent_count=0.

Source files
------------

// File: rtl/ftdi_tx.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_tx
// Description : FTDI synchronous-FIFO transmit side. Byte FIFO feeding a
//               burst-limited write engine sharing the data bus with RX.
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk_60,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    din,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          txe_n,
    input  logic                          rx_busy,
    output logic                          wr_n,
    output logic                          data_oe,
    output logic [7:0]                    data_out,
    output logic                          tx_busy,
    output logic [15:0]                   sent_count
);

    localparam int                   c_addr_w    = $clog2(FIFO_DEPTH);
    localparam logic [c_addr_w:0]    c_depth     = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam logic [7:0]           c_max_burst = 8'(MAX_BURST);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_turn    = 2'd1;
    localparam logic [1:0] c_st_send    = 2'd2;
    localparam logic [1:0] c_st_release = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_wr_n_next;
    logic                w_oe_next;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_level;
    logic [7:0]          r_burst;
    logic [7:0]          w_burst_inc;
    logic                r_wr_n;
    logic                r_data_oe;
    logic                r_overflow;
    logic [15:0]         r_sent;
    logic                w_full;
    logic                w_push_ok;
    logic                w_accept;
    logic                w_pop;
    logic                w_burst_done;
    logic                w_drained;

    assign w_full       = (r_level == c_depth);
    assign w_push_ok    = push & ~w_full;
    assign w_accept     = ~r_wr_n & ~txe_n;
    assign w_pop        = w_accept & (r_level != '0);
    assign w_burst_inc  = r_burst + 8'd1;
    assign w_burst_done = w_accept & (w_burst_inc == c_max_burst);
    // Empty is judged after a same-cycle push, so a late byte extends the burst.
    assign w_drained    = w_pop & (r_level == (c_addr_w + 1)'(1)) & ~w_push_ok;

    always_ff @(posedge clk_60) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_wr_n    <= 1'b1;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wr_n    <= w_wr_n_next;
            r_data_oe <= w_oe_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:
                if ((r_level != '0) && !rx_busy && !txe_n) w_state_next = c_st_turn;
            c_st_turn:
                w_state_next = c_st_send;
            c_st_send:
                if (txe_n || w_burst_done || w_drained) w_state_next = c_st_release;
            c_st_release:
                w_state_next = c_st_idle;
            default:
                w_state_next = c_st_idle;
        endcase
        w_wr_n_next = (w_state_next != c_st_send);
        w_oe_next   = (w_state_next == c_st_turn) || (w_state_next == c_st_send);
    end

    always_ff @(posedge clk_60) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_sent     <= 16'd0;
            r_burst    <= 8'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push_ok && w_pop) r_level <= r_level - 1'b1;
            if (push && w_full) r_overflow <= 1'b1;
            if (w_accept)       r_sent     <= r_sent + 16'd1;
            if (r_state == c_st_turn) r_burst <= 8'd0;
            else if (w_accept)        r_burst <= w_burst_inc;
        end
    end

    always_ff @(posedge clk_60) begin
        if (!rst && w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    assign full       = w_full;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign wr_n       = r_wr_n;
    assign data_oe    = r_data_oe;
    assign data_out   = (r_level != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign tx_busy    = (r_state != c_st_idle);
    assign sent_count = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_tx
// Description : Randomized and directed bench for ftdi_tx with a queue-based
//               reference model and bus-protocol checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_tx;

    localparam int DEPTH = 16;
    localparam int MAXB  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        txe_n = 1'b1;
    logic        rx_busy = 1'b0;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic        wr_n;
    logic        data_oe;
    logic [7:0]  data_out;
    logic        tx_busy;
    logic [15:0] sent_count;

    ftdi_tx #(.FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk_60     (clk),
        .rst        (rst),
        .push       (push),
        .din        (din),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .txe_n      (txe_n),
        .rx_busy    (rx_busy),
        .wr_n       (wr_n),
        .data_oe    (data_oe),
        .data_out   (data_out),
        .tx_busy    (tx_busy),
        .sent_count (sent_count)
    );

    always #8 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference model state
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_sent = 16'd0;
    bit          mvalid = 1'b0;
    bit          after_rst = 1'b0;
    bit          exp_wr_n_valid = 1'b0;
    logic        exp_wr_n = 1'b1;
    bit          exp_idle_valid = 1'b0;
    bit          exp_start_valid = 1'b0;
    logic        exp_tx_busy = 1'b0;
    int          burst = 0;
    int          hi_run = 0;
    logic        prev_wr_n = 1'b1;

    // Checks what the last edge produced, then predicts the next edge.
    always @(negedge clk) begin
        bit in_turn, in_rel, acc;
        int sz;
        logic [7:0] e;
        in_turn = 1'b0;
        in_rel  = 1'b0;
        if (mvalid) begin
            chk("level", 32'(level), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("sent_count", 32'(sent_count), 32'(m_sent));
            if (after_rst) begin
                chk("rst_outputs", {28'd0, wr_n, data_oe, tx_busy, 1'b0}, 32'h8);
                chk("rst_data_out", 32'(data_out), 32'h0);
            end
            if (exp_wr_n_valid) chk("wr_n_seq", 32'(wr_n), 32'(exp_wr_n));
            if (exp_idle_valid) chk("release_to_idle", 32'(tx_busy), 32'h0);
            if (exp_start_valid) begin
                chk("idle_start", 32'(tx_busy), 32'(exp_tx_busy));
                in_turn = exp_tx_busy;
            end
            if (in_turn) chk("turn_bus", {30'd0, wr_n, data_oe}, 32'h3);
            if (exp_wr_n_valid && exp_wr_n === 1'b1) begin
                in_rel = 1'b1;
                chk("release_bus", {30'd0, data_oe, tx_busy}, 32'h1);
            end
            if (wr_n === 1'b0) chk("send_bus", {30'd0, data_oe, tx_busy}, 32'h3);
            if (wr_n === 1'b0 && prev_wr_n === 1'b1) chk("wr_n_gap", 32'(hi_run >= 3), 32'h1);
        end
        hi_run    = (wr_n === 1'b1) ? hi_run + 1 : 0;
        prev_wr_n = wr_n;
        if (rst) begin
            q.delete();
            m_ovf           = 1'b0;
            m_sent          = 16'd0;
            mvalid          = 1'b1;
            after_rst       = 1'b1;
            exp_wr_n_valid  = 1'b0;
            exp_idle_valid  = 1'b0;
            exp_start_valid = 1'b0;
            burst           = 0;
            hi_run          = 1;
        end else if (mvalid) begin
            after_rst = 1'b0;
            if (wr_n !== 1'b0) burst = 0;
            sz  = q.size();
            acc = (wr_n === 1'b0) && (txe_n == 1'b0);
            if (acc) begin
                if (sz == 0) fail("pop_empty");
                else begin
                    e = q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e));
                end
                m_sent++;
                burst++;
            end
            if (push) begin
                if (sz < DEPTH) q.push_back(din);
                else m_ovf = 1'b1;
            end
            if (in_turn) begin
                exp_wr_n_valid = 1'b1;
                exp_wr_n       = 1'b0;
            end else if (wr_n === 1'b0) begin
                exp_wr_n_valid = 1'b1;
                exp_wr_n = txe_n || (acc && (burst == MAXB || q.size() == 0));
            end else begin
                exp_wr_n_valid = 1'b0;
            end
            exp_idle_valid  = in_rel;
            exp_start_valid = (tx_busy === 1'b0);
            exp_tx_busy     = (sz > 0) && !rx_busy && !txe_n;
        end
    end

    task automatic drive(input bit p, input logic [7:0] d, input bit t, input bit r);
        @(posedge clk);
        #1;
        push    = p;
        din     = d;
        txe_n   = t;
        rx_busy = r;
    endtask

    task automatic idle(input int n, input bit t);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, t, 1'b0);
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (wr_n === 1'b0) ok = 1'b1;
        end
        if (!ok) fail("send_timeout");
    endtask

    initial begin
        #(16 * 40000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit rxs;
        int rate;
        rst = 1'b1;
        idle(3, 1'b1);
        rst = 1'b0;
        idle(2, 1'b0);

        // Three bytes, one short burst
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        idle(12, 1'b0);

        // Twelve bytes split by the burst limit
        for (int i = 0; i < 12; i++) drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        idle(40, 1'b0);

        // Flow control drops in the second SEND cycle
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        wait_send(ok);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(5, 1'b1);
        idle(20, 1'b0);

        // Receive side holds the bus
        drive(1'b1, 8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        idle(10, 1'b0);

        // Fill, then overflow with 0xAA
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom_range(0, 127)), 1'b1, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        idle(60, 1'b0);

        // Reset in the middle of SEND
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        wait_send(ok);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        idle(10, 1'b0);

        // Randomized traffic in phases of varying push pressure
        rxs = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            case (i / 500)
                0:       rate = 30;
                1:       rate = 80;
                2:       rate = 10;
                3:       rate = 95;
                default: rate = 50;
            endcase
            if ($urandom_range(0, 19) == 0) rxs = ~rxs;
            drive(($urandom_range(0, 99) < rate), 8'($urandom),
                  ($urandom_range(0, 99) < 12), rxs);
            rst = ($urandom_range(0, 699) == 0);
        end
        rst = 1'b0;

        idle(120, 1'b0);
        @(negedge clk);
        chk("drain_level", 32'(level), 32'h0);
        chk("drain_busy", {30'd0, tx_busy, wr_n}, 32'h1);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
